// File: rtl/freq_meter_scan.sv
`default_nettype none
//==============================================================================
// Module   : freq_meter_scan
// Brief    : Gated frequency meter. It counts input edges over a fixed gate,
//            converts the count to BCD by shift-add-3, and scans the result
//            onto a multiplexed common-anode seven-segment display.
// Revision : 1.0 - initial release
//==============================================================================
module freq_meter_scan #(
    parameter int DIGITS      = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int SCAN_DIV    = 50_000
) (
    input  logic              FPGA_clk,
    input  logic              clr,
    input  logic              sig_in,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] ScanEn,
    output logic [7:0]        Dout
);

    function automatic logic [63:0] f_max_val(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    localparam int c_BCD_W  = 4 * DIGITS;
    localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int c_CONV_W = $clog2(CNT_W);
    localparam int c_DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [63:0]         c_MAX_VAL   = f_max_val(DIGITS);
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [c_CONV_W-1:0] c_CONV_LAST = c_CONV_W'(CNT_W - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [7:0]          c_SEG_DASH  = 8'hBF;
    localparam logic [7:0]          c_SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_CONV = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sig_meta;
    logic                  r_sig_sync;
    logic                  r_sig_prev;
    logic                  w_edge;
    logic [CNT_W-1:0]      r_count;
    logic                  r_sat;
    logic [c_GATE_W-1:0]   r_gate_cnt;
    logic [c_CONV_W-1:0]   r_conv_cnt;
    logic [c_BCD_W-1:0]    r_bcd;
    logic [c_BCD_W-1:0]    w_bcd_adj;
    logic                  r_ovf_pend;
    logic                  w_gate_start;

    logic [c_BCD_W-1:0]    r_disp_bcd;
    logic                  r_disp_ovf;
    logic [c_BCD_W-1:0]    w_disp_bcd_next;
    logic                  w_disp_ovf_next;
    logic [c_DIV_W-1:0]    r_scan_div;
    logic [c_IDX_W-1:0]    r_scan_idx;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic                  w_lead;
    logic                  w_blank;
    logic [3:0]            w_digit;
    logic [DIGITS-1:0]     w_scan_en_next;
    logic [7:0]            w_dout_next;
    logic [DIGITS-1:0]     r_scan_en;
    logic [7:0]            r_dout;

    assign w_edge       = r_sig_sync & ~r_sig_prev;
    assign w_gate_start = (w_state_next == S_GATE) && (r_state != S_GATE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_GATE;
            S_GATE: if (r_gate_cnt == c_GATE_LAST) w_state_next = S_CONV;
            S_CONV: if (r_conv_cnt == c_CONV_LAST) w_state_next = S_SHOW;
            S_SHOW: w_state_next = cont ? S_GATE : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge FPGA_clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_sig_meta <= 1'b0;
            r_sig_sync <= 1'b0;
            r_sig_prev <= 1'b0;
            r_count    <= '0;
            r_sat      <= 1'b0;
            r_gate_cnt <= '0;
            r_conv_cnt <= '0;
            r_bcd      <= '0;
            r_ovf_pend <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sig_meta <= sig_in;
            r_sig_sync <= r_sig_meta;
            r_sig_prev <= r_sig_sync;

            if (w_gate_start) begin
                r_count    <= '0;
                r_sat      <= 1'b0;
                r_gate_cnt <= '0;
            end else if (r_state == S_GATE) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
                if (w_edge) begin
                    if (r_count == {CNT_W{1'b1}})
                        r_sat <= 1'b1;
                    else
                        r_count <= r_count + 1'b1;
                end
                if (w_state_next == S_CONV) begin
                    r_bcd      <= '0;
                    r_conv_cnt <= '0;
                end
            end else if (r_state == S_CONV) begin
                // Range check reads the count before its first shift
                if (r_conv_cnt == '0)
                    r_ovf_pend <= r_sat || (64'(r_count) > c_MAX_VAL);
                {r_bcd, r_count} <= {w_bcd_adj, r_count} << 1;
                r_conv_cnt       <= r_conv_cnt + 1'b1;
            end
        end
    end

    assign w_disp_bcd_next = (r_state == S_SHOW) ? r_bcd : r_disp_bcd;
    assign w_disp_ovf_next = (r_state == S_SHOW) ? r_ovf_pend : r_disp_ovf;
    assign w_idx_next      = (r_scan_div != c_DIV_LAST) ? r_scan_idx :
                             (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + 1'b1;

    // Segment and enable outputs are built from next-cycle values so both registers switch together
    always_comb begin
        w_lead  = 1'b1;
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (c_IDX_W'(i) == w_idx_next) begin
                w_digit = w_disp_bcd_next[4*i +: 4];
                w_blank = w_lead && (i != 0) && (w_disp_bcd_next[4*i +: 4] == 4'd0);
            end
            if (w_disp_bcd_next[4*i +: 4] != 4'd0) w_lead = 1'b0;
        end
    end

    always_comb begin
        w_scan_en_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_IDX_W'(i) == w_idx_next) w_scan_en_next[i] = 1'b0;
        end
    end

    assign w_dout_next = w_disp_ovf_next ? c_SEG_DASH :
                         w_blank         ? c_SEG_BLANK : f_seg(w_digit);

    always_ff @(posedge FPGA_clk or negedge clr) begin
        if (!clr) begin
            r_disp_bcd <= '0;
            r_disp_ovf <= 1'b0;
            r_scan_div <= '0;
            r_scan_idx <= '0;
            r_scan_en  <= ~DIGITS'(1);
            r_dout     <= 8'hC0;
        end else begin
            r_disp_bcd <= w_disp_bcd_next;
            r_disp_ovf <= w_disp_ovf_next;
            r_scan_div <= (r_scan_div == c_DIV_LAST) ? '0 : r_scan_div + 1'b1;
            r_scan_idx <= w_idx_next;
            r_scan_en  <= w_scan_en_next;
            r_dout     <= w_dout_next;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign ovf    = r_disp_ovf;
    assign ScanEn = r_scan_en;
    assign Dout   = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_scan.sv
`default_nettype none
//==============================================================================
// Module   : tb_freq_meter_scan
// Brief    : Directed bench for freq_meter_scan with a cycle-level result model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_freq_meter_scan;

    localparam int G    = 1000;
    localparam int C    = 16;
    localparam int SD   = 4;
    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sig_in = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       busy, ovf;
    logic [3:0] scan_en;
    logic [7:0] dout;

    logic       sig2 = 1'b0;
    logic       start2 = 1'b0;
    logic       cont2 = 1'b0;
    logic       busy2, ovf2;
    logic [1:0] scan_en2;
    logic [7:0] dout2;

    always #5 clk = ~clk;

    freq_meter_scan #(.DIGITS(4), .CNT_W(16), .GATE_CYCLES(G), .SCAN_DIV(SD)) u_dut (
        .FPGA_clk(clk), .clr(clr), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy), .ovf(ovf), .ScanEn(scan_en), .Dout(dout)
    );

    freq_meter_scan #(.DIGITS(2), .CNT_W(16), .GATE_CYCLES(G), .SCAN_DIV(SD)) u_dut2 (
        .FPGA_clk(clk), .clr(clr), .sig_in(sig2), .start(start2), .cont(cont2),
        .busy(busy2), .ovf(ovf2), .ScanEn(scan_en2), .Dout(dout2)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int half1  = 0;
    int half2  = 0;
    int drops  = 0;
    bit mon_en = 1'b0;

    logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] scan_tab [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event at %0t", name, $time);
    endtask

    // Expected segment code from the displayed integer, by decimal arithmetic
    function automatic logic [7:0] exp_seg(input int val, input bit ov, input int idx);
        int p;
        p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        if (ov) return 8'hBF;
        if (idx > 0 && val < p) return 8'hFF;
        return seg_tab[(val / p) % 10];
    endfunction

    initial forever begin
        @(negedge clk);
        cyc++;
    end

    initial forever begin : g_sig1
        int ph;
        @(negedge clk);
        if (half1 == 0) begin
            sig_in = 1'b0;
            ph     = 0;
        end else begin
            ph++;
            if (ph >= half1) begin
                ph     = 0;
                sig_in = ~sig_in;
            end
        end
    end

    initial forever begin : g_sig2
        int ph;
        @(negedge clk);
        if (half2 == 0) begin
            sig2 = 1'b0;
            ph   = 0;
        end else begin
            ph++;
            if (ph >= half2) begin
                ph   = 0;
                sig2 = ~sig2;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en && !busy) drops++;
    end

    // Model: measurement windows and results from edge arithmetic, checked every cycle
    initial begin : g_model
        bit         m_active, m_sat, disp_ovf, h1, h2, h3, rising, was_idle;
        int         m_age, m_cnt, disp_val, k, idx;
        logic [3:0] exp_en;
        m_active = 0; m_sat = 0; disp_ovf = 0; h1 = 0; h2 = 0; h3 = 0;
        m_age = 0; m_cnt = 0; disp_val = 0; k = 0;
        forever begin
            @(posedge clk);
            if (!clr) begin
                k = 0; m_active = 0; m_age = 0; m_cnt = 0; m_sat = 0;
                disp_val = 0; disp_ovf = 0; h1 = 0; h2 = 0; h3 = 0;
            end else begin
                rising   = h2 && !h3;
                was_idle = !m_active;
                if (m_active) begin
                    m_age++;
                    if (m_age <= G && rising) begin
                        if (m_cnt == 65535) m_sat = 1;
                        else m_cnt++;
                    end
                    if (m_age == G + C + 1) begin
                        disp_val = m_cnt;
                        disp_ovf = m_sat || (m_cnt > MAXV);
                        if (cont) begin
                            m_age = 0; m_cnt = 0; m_sat = 0;
                        end else begin
                            m_active = 0;
                        end
                    end
                end
                if (was_idle && start) begin
                    m_active = 1; m_age = 0; m_cnt = 0; m_sat = 0;
                end
                h3 = h2; h2 = h1; h1 = sig_in;
                k++;
            end
            #2;
            idx    = (k / SD) % D;
            exp_en = ~(4'b0001 << idx);
            check("busy", busy, m_active);
            check("ovf", ovf, disp_ovf);
            check("ScanEn", scan_en, exp_en);
            check("Dout", dout, exp_seg(disp_val, disp_ovf, idx));
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_dig(input bit second, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ex [0:3];
        logic [3:0] want;
        bit         found;
        int         nd;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        nd = second ? 2 : 4;
        for (int i = 0; i < nd; i++) begin
            want  = ~(4'b0001 << i);
            found = 0;
            for (int w = 0; w < 24 && !found; w++) begin
                @(negedge clk);
                #1;
                if (second ? (scan_en2 == want[1:0]) : (scan_en == want)) begin
                    found = 1;
                    check($sformatf("digit%0d%s", i, second ? "_dut2" : ""),
                          second ? dout2 : dout, ex[i]);
                end
            end
            if (!found) timeout_fail($sformatf("scan_to_digit%0d", i));
        end
    endtask

    task automatic pulse_start(input bit second);
        @(negedge clk);
        if (second) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        if (second) start2 = 1'b0; else start = 1'b0;
    endtask

    task automatic measure_busy(input bit second, output int nb);
        nb = 0;
        #1;
        while ((second ? busy2 : busy) && nb < 1200) begin
            nb++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int nb, t0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ScanEn", scan_en, 4'b1110);
        check("rst_Dout", dout, 8'hC0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_ScanEn_dut2", scan_en2, 2'b10);

        // Scan rotation, each digit held SD cycles
        @(negedge clk);
        clr = 1'b1;
        #2;
        check("scan_k0", scan_en, scan_tab[0]);
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #3;
            check($sformatf("scan_k%0d", k), scan_en, scan_tab[k / 4]);
        end

        // Basic measurement: period 10 over 1000 cycles -> 100
        half1 = 5;
        repeat (30) @(negedge clk);
        pulse_start(0);
        measure_busy(0, nb);
        check("busy_len", nb, 1017);
        check("basic_ovf", ovf, 1'b0);
        check_dig(0, 8'hC0, 8'hC0, 8'hF9, 8'hFF);

        // Two-digit instance: period 2 -> 500 -> overflow dashes
        half2 = 1;
        repeat (10) @(negedge clk);
        pulse_start(1);
        measure_busy(1, nb);
        check("busy_len_dut2", nb, 1017);
        check("ovf_dut2", ovf2, 1'b1);
        check_dig(1, 8'hBF, 8'hBF, 8'hFF, 8'hFF);
        half2 = 0;

        // Continuous mode with a period change between measurements
        cont = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start(0);
        t0     = cyc;
        drops  = 0;
        mon_en = 1'b1;
        wait_until(t0 + 500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 1010);
        half1 = 10;
        wait_until(t0 + 1020);
        check_dig(0, 8'hC0, 8'hC0, 8'hF9, 8'hFF);
        wait_until(t0 + 1500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 2040);
        check_dig(0, 8'hC0, 8'h92, 8'hFF, 8'hFF);
        wait_until(t0 + 2100);
        cont = 1'b0;
        wait_until(t0 + 3045);
        mon_en = 1'b0;
        check("cont_busy_drops", drops, 0);
        measure_busy(0, nb);
        check("cont_busy_end", busy, 1'b0);
        check_dig(0, 8'hC0, 8'h92, 8'hFF, 8'hFF);

        // Reset halfway through the gate
        half1 = 5;
        repeat (20) @(negedge clk);
        pulse_start(0);
        t0 = cyc;
        wait_until(t0 + 500);
        clr = 1'b0;
        #2;
        check("midrst_busy", busy, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_ScanEn", scan_en, 4'b1110);
        check("midrst_Dout", dout, 8'hC0);
        @(negedge clk);
        clr = 1'b1;
        repeat (1200) @(negedge clk);
        #1;
        check("midrst_busy_late", busy, 1'b0);
        check("midrst_ovf_late", ovf, 1'b0);
        check_dig(0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
